// File: rtl/frame_header_packer.sv
// Buffers one input frame, then replays it as a length header followed by the body
// words over a req/ack handshake. Oversize frames are swallowed and flagged.
module frame_header_packer #(
   parameter int unsigned ParamA = 8,
   parameter int unsigned Depth  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [ParamA-1:0] i_data,
   input  logic              i_last,
   output logic              o_req,
   input  logic              i_ack,
   output logic [ParamA-1:0] o_data,
   output logic              o_head,
   output logic              o_tail,
   output logic              o_overflow
);

   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

   typedef enum logic [1:0] {StFill, StDrop, StHead, StBody} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [CntW-1:0]   rd_q, rd_d;
   logic              ovf_q, ovf_d;
   logic [ParamA-1:0] buf_q [Depth];
   logic [ParamA-1:0] buf_d [Depth];

   logic in_xfer;
   logic out_xfer;
   logic is_tail;

   assign in_xfer    = i_valid & o_ready;
   assign out_xfer   = o_req & i_ack;
   assign is_tail    = (rd_q == count_q - CntW'(1));
   assign o_overflow = ovf_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= StFill;
         count_q <= '0;
         rd_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         ovf_q   <= ovf_d;
      end
   end

   // Buffer contents are meaningless until count says otherwise, so no reset.
   always_ff @(posedge i_clk) begin
      buf_q <= buf_d;
   end

   always_comb begin
      o_ready = 1'b0;
      o_req   = 1'b0;
      o_head  = 1'b0;
      o_tail  = 1'b0;
      o_data  = '0;
      unique case (state_q)
         StFill, StDrop: o_ready = i_rst_n;
         StHead: begin
            o_req              = 1'b1;
            o_head             = 1'b1;
            o_data[CntW-1:0]   = count_q;
         end
         StBody: begin
            o_req  = 1'b1;
            o_data = buf_q[rd_q[IdxW-1:0]];
            o_tail = is_tail;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rd_d    = rd_q;
      ovf_d   = 1'b0;
      buf_d   = buf_q;
      unique case (state_q)
         StFill: begin
            if (in_xfer) begin
               if (count_q < CntW'(Depth)) begin
                  buf_d[count_q[IdxW-1:0]] = i_data;
                  count_d                  = count_q + CntW'(1);
                  if (i_last) state_d = StHead;
               end else if (i_last) begin
                  // One word past capacity and already the last: flag and restart.
                  ovf_d   = 1'b1;
                  count_d = '0;
               end else begin
                  state_d = StDrop;
               end
            end
         end
         StDrop: begin
            if (in_xfer && i_last) begin
               ovf_d   = 1'b1;
               count_d = '0;
               state_d = StFill;
            end
         end
         StHead: begin
            if (out_xfer) begin
               rd_d    = '0;
               state_d = StBody;
            end
         end
         StBody: begin
            if (out_xfer) begin
               if (is_tail) begin
                  count_d = '0;
                  rd_d    = '0;
                  state_d = StFill;
               end else begin
                  rd_d = rd_q + CntW'(1);
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_frame_header_packer.sv
// Directed bench for frame_header_packer: per-cycle vectors of inputs and expected outputs.
module tb_frame_header_packer;

   logic       clk;
   logic       rst_n;
   logic       valid;
   logic       ready;
   logic [7:0] din;
   logic       last;
   logic       req;
   logic       ack;
   logic [7:0] dout;
   logic       head;
   logic       tail;
   logic       ovf;

   int n_checks = 0;
   int n_err    = 0;

   frame_header_packer #(
      .ParamA (8),
      .Depth  (4)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (valid),
      .o_ready    (ready),
      .i_data     (din),
      .i_last     (last),
      .o_req      (req),
      .i_ack      (ack),
      .o_data     (dout),
      .o_head     (head),
      .o_tail     (tail),
      .o_overflow (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       ack;
      logic       e_ready;
      logic       e_req;
      logic       e_head;
      logic       e_tail;
      logic [7:0] e_data;
      logic       e_ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                               input logic l, input logic a, input logic er,
                               input logic eq, input logic eh, input logic et,
                               input logic [7:0] ed, input logic eo);
      vec_t x;
      x.rst_n = r;  x.valid = v;  x.data = d;  x.last = l;  x.ack = a;
      x.e_ready = er; x.e_req = eq; x.e_head = eh; x.e_tail = et;
      x.e_data = ed;  x.e_ovf = eo;
      return x;
   endfunction

   // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
   task automatic apply(input vec_t v, input string nm);
      rst_n = v.rst_n;
      valid = v.valid;
      din   = v.data;
      last  = v.last;
      ack   = v.ack;
      #1;
      n_checks++;
      if ({ready, req, head, tail, dout, ovf} !==
          {v.e_ready, v.e_req, v.e_head, v.e_tail, v.e_data, v.e_ovf}) begin
         n_err++;
         $display("FAIL %s: got rdy=%b req=%b head=%b tail=%b data=%h ovf=%b, want rdy=%b req=%b head=%b tail=%b data=%h ovf=%b",
                  nm, ready, req, head, tail, dout, ovf,
                  v.e_ready, v.e_req, v.e_head, v.e_tail, v.e_data, v.e_ovf);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      din   = '0;
      last  = 1'b0;
      ack   = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      //            rst v  data  l  a   rdy req hd tl  data  ovf
      // reset state
      tbl.push_back(mk(0, 0, 8'h00, 0, 0,  0, 0, 0, 0, 8'h00, 0));
      // 3-word frame, ack held high
      tbl.push_back(mk(1, 1, 8'hA1, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'hB2, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'hC3, 1, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h03, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'hA1, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'hB2, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 1, 8'hC3, 0));
      // single-word frame
      tbl.push_back(mk(1, 1, 8'h55, 1, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h01, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 1, 8'h55, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      // 6-word oversize frame through DROP, ack ignored while idle
      tbl.push_back(mk(1, 1, 8'h10, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h11, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h12, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h13, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h14, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h15, 1, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  1, 0, 0, 0, 8'h00, 1));
      // following 2-word frame is normal
      tbl.push_back(mk(1, 1, 8'h20, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h21, 1, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h02, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'h20, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 1, 8'h21, 0));
      // 5-word frame: last arrives with buffer full, stays in FILL
      tbl.push_back(mk(1, 1, 8'h30, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h31, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h32, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h33, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'h34, 1, 0,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 1));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 0));
      // back-to-back 2-word frames with valid held high
      tbl.push_back(mk(1, 1, 8'hAA, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'hBB, 1, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'hCC, 0, 1,  0, 1, 1, 0, 8'h02, 0));
      tbl.push_back(mk(1, 1, 8'hCC, 0, 1,  0, 1, 0, 0, 8'hAA, 0));
      tbl.push_back(mk(1, 1, 8'hCC, 0, 1,  0, 1, 0, 1, 8'hBB, 0));
      tbl.push_back(mk(1, 1, 8'hCC, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 1, 8'hDD, 1, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h02, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'hCC, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 1, 8'hDD, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

      // Exact-fit 4-word frame with stalls; valid during stalls must be ignored.
      apply(mk(1, 1, 8'h40, 0, 0,  1, 0, 0, 0, 8'h00, 0), "t3_w0");
      apply(mk(1, 1, 8'h41, 0, 0,  1, 0, 0, 0, 8'h00, 0), "t3_w1");
      apply(mk(1, 1, 8'h42, 0, 0,  1, 0, 0, 0, 8'h00, 0), "t3_w2");
      apply(mk(1, 1, 8'h43, 1, 0,  1, 0, 0, 0, 8'h00, 0), "t3_w3");
      for (int k = 0; k < 3; k++)
         apply(mk(1, 1, 8'h99, 0, 0,  0, 1, 1, 0, 8'h04, 0), "t3_head_stall");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h04, 0), "t3_head_ack");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'h40, 0), "t3_b0");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'h41, 0), "t3_b1");
      for (int k = 0; k < 2; k++)
         apply(mk(1, 0, 8'h00, 0, 0,  0, 1, 0, 0, 8'h42, 0), "t3_b2_stall");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'h42, 0), "t3_b2");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 1, 8'h43, 0), "t3_b3_tail");
      apply(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 0), "t3_idle");

      // Reset while the second body word is presented.
      apply(mk(1, 1, 8'h50, 0, 1,  1, 0, 0, 0, 8'h00, 0), "t5_w0");
      apply(mk(1, 1, 8'h51, 0, 1,  1, 0, 0, 0, 8'h00, 0), "t5_w1");
      apply(mk(1, 1, 8'h52, 1, 1,  1, 0, 0, 0, 8'h00, 0), "t5_w2");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h03, 0), "t5_head");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'h50, 0), "t5_b0");
      apply(mk(0, 0, 8'h00, 0, 1,  0, 1, 0, 0, 8'h51, 0), "t5_rst_at_b1");
      apply(mk(0, 0, 8'h00, 0, 1,  0, 0, 0, 0, 8'h00, 0), "t5_after_rst");
      apply(mk(1, 1, 8'h77, 1, 1,  1, 0, 0, 0, 8'h00, 0), "t5_new_w0");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 1, 0, 8'h01, 0), "t5_new_head");
      apply(mk(1, 0, 8'h00, 0, 1,  0, 1, 0, 1, 8'h77, 0), "t5_new_tail");
      apply(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 0), "t5_idle");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
